// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : n64_pkg
//  Purpose  : Shared constants for the N64 controller-line receive path:
//             FSM state encoding, error codes and 50 MHz timing defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package n64_pkg;

  // Receiver FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARMED     = 3'd1;
  localparam logic [2:0] ST_LOW       = 3'd2;
  localparam logic [2:0] ST_HIGH      = 3'd3;
  localparam logic [2:0] ST_STOP_LOW  = 3'd4;
  localparam logic [2:0] ST_STOP_HIGH = 3'd5;

  // Error codes reported alongside the error pulse
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_LONG_LOW = 2'b10;
  localparam logic [1:0] ERR_TRUNC    = 2'b11;

  // Default timing at a 50 MHz system clock
  localparam int DEF_NUM_BITS      = 32;
  localparam int DEF_CNT_W         = 10;
  localparam int DEF_BIT_THRESH    = 100;
  localparam int DEF_MAX_LOW       = 250;
  localparam int DEF_MAX_HIGH      = 250;
  localparam int DEF_START_TIMEOUT = 1000;
  localparam int DEF_GLITCH_CYCLES = 3;

endpackage : n64_pkg
`default_nettype wire

// File: rtl/n64_frame_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : n64_frame_receiver_if
//  Purpose  : Control/status bundle between the frame receiver and its user
//             (transmit-side arming logic, line pad, register file).
//  Revision : 1.0 - initial release
// ============================================================================
interface n64_frame_receiver_if
  import n64_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS
);
  logic                start;
  logic                data_in;
  logic                busy;
  logic                data_valid;
  logic [NUM_BITS-1:0] data;
  logic                error;
  logic [1:0]          err_code;

  // User side: arms the receiver, supplies the line, consumes results
  modport master (
    output start, data_in,
    input  busy, data_valid, data, error, err_code
  );

  // Receiver side
  modport slave (
    input  start, data_in,
    output busy, data_valid, data, error, err_code
  );
endinterface : n64_frame_receiver_if
`default_nettype wire

// File: rtl/n64_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : n64_line_filter
//  Purpose  : Two-flop synchroniser plus glitch filter for an asynchronous,
//             idle-high open-drain line. Produces a filtered level and
//             one-cycle rise/fall strobes aligned with level changes.
//  Revision : 1.0 - initial release
// ============================================================================
module n64_line_filter
  import n64_pkg::*;
#(
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               RUN_W    = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(GLITCH_CYCLES - 1);

  logic [1:0]       sync;
  logic [RUN_W-1:0] run_cnt;

  // Bring the raw line into the clock domain; idle level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], line_in};
    end
  end

  // Accept a new level only after GLITCH_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= 1'b1;
      run_cnt <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        level   <= sync[1];
        rise    <= sync[1];
        fall    <= ~sync[1];
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule : n64_line_filter
`default_nettype wire

// File: rtl/n64_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : n64_frame_receiver
//  Purpose  : Receives one N64 serial frame (NUM_BITS data bits MSB first plus
//             a stop bit). Bits are classified by measured low-pulse width;
//             timeouts per phase report start timeout, long low or truncation.
//  Revision : 1.0 - initial release
// ============================================================================
module n64_frame_receiver
  import n64_pkg::*;
#(
  parameter int NUM_BITS      = DEF_NUM_BITS,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int BIT_THRESH    = DEF_BIT_THRESH,
  parameter int MAX_LOW       = DEF_MAX_LOW,
  parameter int MAX_HIGH      = DEF_MAX_HIGH,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  n64_frame_receiver_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_BITS + 1);

  // Limits are compared against the counter value before it is advanced, so a
  // phase that began with the counter at 1 trips on its Nth cycle.
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] LOW_LIMIT  = CNT_W'(MAX_LOW - 1);
  localparam logic [CNT_W-1:0] HIGH_LIMIT = CNT_W'(MAX_HIGH - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STOP_HOLD  = CNT_W'(GLITCH_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BITS);

  logic [2:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [IDX_W-1:0]    bit_idx;
  logic                busy;
  logic                data_valid;
  logic                error;
  logic [1:0]          err_code;
  logic [NUM_BITS-1:0] data;
  logic                level;
  logic                rise;
  logic                fall;
  logic                bit_val;

  n64_line_filter #(
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_line_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (bus.data_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  // Saturating phase counter and short-low-means-one bit decision
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign bit_val = (cnt < THRESH);

  assign bus.busy       = busy;
  assign bus.data_valid = data_valid;
  assign bus.data       = data;
  assign bus.error      = error;
  assign bus.err_code   = err_code;

  // Frame FSM: one shared counter measures the current phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      data       <= '0;
    end else begin
      data_valid <= 1'b0;
      error      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_ARMED;
            busy     <= 1'b1;
            err_code <= ERR_NONE;
            bit_idx  <= '0;
            cnt      <= '0;
          end
        end

        ST_ARMED: begin
          if (fall) begin
            state <= ST_LOW;
            cnt   <= CNT_W'(1);
          end else if (cnt >= TMO_LIMIT) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_LOW: begin
          if (rise) begin
            data    <= (data << 1) | NUM_BITS'(bit_val);
            bit_idx <= bit_idx + 1'b1;
            cnt     <= CNT_W'(1);
            state   <= ST_HIGH;
          end else if (cnt >= LOW_LIMIT) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_LONG_LOW;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            cnt   <= CNT_W'(1);
            state <= (bit_idx == LAST_IDX) ? ST_STOP_LOW : ST_LOW;
          end else if (cnt >= HIGH_LIMIT) begin
            // Covers both a short frame and a missing stop bit
            state    <= ST_IDLE;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_TRUNC;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_STOP_LOW: begin
          if (rise) begin
            if (bit_val) begin
              cnt   <= CNT_W'(1);
              state <= ST_STOP_HIGH;
            end else begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_LONG_LOW;
            end
          end else if (cnt >= LOW_LIMIT) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_LONG_LOW;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_STOP_HIGH: begin
          if (fall) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_TRUNC;
          end else if (level && (cnt >= STOP_HOLD)) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            data_valid <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : n64_frame_receiver
`default_nettype wire

// File: tb/tb_n64_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_frame_receiver
//  Purpose  : Scoreboard bench for n64_frame_receiver: a default 32-bit
//             instance and an 8-bit instance driven with directed frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n64_frame_receiver;
  import n64_pkg::*;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset0, reset1;
  logic line0, line1;
  logic start0, start1;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  n64_frame_receiver_if #(.NUM_BITS(32)) bus0 ();
  n64_frame_receiver_if #(.NUM_BITS(8))  bus1 ();

  assign bus0.start   = start0;
  assign bus0.data_in = line0;
  assign bus1.start   = start1;
  assign bus1.data_in = line1;

  n64_frame_receiver #(.NUM_BITS(32)) dut0 (.clk(clk), .reset(reset0), .bus(bus0));
  n64_frame_receiver #(.NUM_BITS(8))  dut1 (.clk(clk), .reset(reset1), .bus(bus1));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard compare, called by the monitors whenever a pulse appears
  task automatic check_pulse(int inst, logic v, logic e, logic [1:0] code,
                             logic [63:0] d, logic b);
    exp_t x;
    int   n;
    n = (inst == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL unexpected_pulse inst%0d: valid=%0b error=%0b code=%0d, expected no pulse",
               inst, v, e, code);
      return;
    end
    if (inst == 0) x = q0.pop_front();
    else           x = q1.pop_front();
    chk($sformatf("inst%0d_pulse_error", inst), 64'(e), 64'(x.is_err));
    chk($sformatf("inst%0d_pulse_valid", inst), 64'(v), 64'(!x.is_err));
    chk($sformatf("inst%0d_err_code", inst), 64'(code), 64'(x.code));
    if (!x.is_err) chk($sformatf("inst%0d_data", inst), d, x.data);
    chk($sformatf("inst%0d_busy_at_pulse", inst), 64'(b), 64'd0);
  endtask

  always @(negedge clk) begin
    if (bus0.data_valid === 1'b1 || bus0.error === 1'b1)
      check_pulse(0, bus0.data_valid, bus0.error, bus0.err_code, 64'(bus0.data), bus0.busy);
  end

  always @(negedge clk) begin
    if (bus1.data_valid === 1'b1 || bus1.error === 1'b1)
      check_pulse(1, bus1.data_valid, bus1.error, bus1.err_code, 64'(bus1.data), bus1.busy);
  end

  task automatic expect_valid(int inst, logic [63:0] d);
    exp_t x;
    x.is_err = 1'b0; x.code = ERR_NONE; x.data = d;
    if (inst == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic expect_err(int inst, logic [1:0] c);
    exp_t x;
    x.is_err = 1'b1; x.code = c; x.data = '0;
    if (inst == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  function automatic logic busy_of(int inst);
    return (inst == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic hold(int inst, logic v, int n);
    if (inst == 0) line0 = v; else line1 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(int inst, int lo, int hi);
    hold(inst, 1'b0, lo);
    hold(inst, 1'b1, hi);
  endtask

  task automatic send_std(int inst, logic b);
    if (b) send_bit(inst, 50, 150);
    else   send_bit(inst, 150, 50);
  endtask

  task automatic send_bits(int inst, logic [63:0] w, int n);
    for (int i = n - 1; i >= 0; i--) send_std(inst, w[i]);
  endtask

  task automatic send_stop(int inst);
    hold(inst, 1'b0, 50);
    hold(inst, 1'b1, 10);
  endtask

  task automatic pulse_start(int inst);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    if (inst == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  // Bounded wait for the receiver to drop busy, then confirm all expected pulses arrived
  task automatic wait_idle(int inst, int budget, string name);
    int n = 0;
    while (busy_of(inst) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_idle"}, 64'(busy_of(inst)), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_pending"}, 64'((inst == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    logic [29:0] tail;
    reset0 = 1'b1; reset1 = 1'b1;
    line0  = 1'b1; line1  = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset state of both instances
    chk("rst_busy0",  64'(bus0.busy), 0);
    chk("rst_valid0", 64'(bus0.data_valid), 0);
    chk("rst_error0", 64'(bus0.error), 0);
    chk("rst_code0",  64'(bus0.err_code), 0);
    chk("rst_data0",  64'(bus0.data), 0);
    chk("rst_busy1",  64'(bus1.busy), 0);
    chk("rst_data1",  64'(bus1.data), 0);
    reset0 = 1'b0; reset1 = 1'b0;
    hold(0, 1'b1, 8);

    // Clean 32-bit frame
    pulse_start(0);
    chk("t1_busy_after_start", 64'(bus0.busy), 1);
    expect_valid(0, 64'h8000_0001);
    send_bits(0, 64'h8000_0001, 32);
    send_stop(0);
    wait_idle(0, 100, "t1");
    hold(0, 1'b1, 20);
    chk("t1_data_hold", 64'(bus0.data), 64'h8000_0001);

    // Start timeout: line stays high
    pulse_start(0);
    expect_err(0, ERR_TIMEOUT);
    hold(0, 1'b1, 995);
    chk("t2_busy_before_timeout", 64'(bus0.busy), 1);
    wait_idle(0, 40, "t2");

    // Fifth bit low too long; later edges ignored
    pulse_start(0);
    expect_err(0, ERR_LONG_LOW);
    send_bits(0, 64'hB, 4);
    hold(0, 1'b0, 240);
    chk("t3_busy_mid_low", 64'(bus0.busy), 1);
    hold(0, 1'b0, 30);
    hold(0, 1'b1, 10);
    wait_idle(0, 20, "t3");
    send_std(0, 1'b1);
    send_std(0, 1'b0);
    hold(0, 1'b1, 10);
    chk("t3_busy_after_edges", 64'(bus0.busy), 0);
    wait_idle(0, 1, "t3_after");

    // Truncated frame: 20 bits then line high
    pulse_start(0);
    expect_err(0, ERR_TRUNC);
    send_bits(0, 64'hABCDE, 20);
    hold(0, 1'b1, 300);
    wait_idle(0, 20, "t4");

    // Threshold 99/100 and 2-cycle low glitches inside high phases
    pulse_start(0);
    expect_valid(0, 64'h9234_5678);
    hold(0, 1'b0, 99);
    hold(0, 1'b1, 70); hold(0, 1'b0, 2); hold(0, 1'b1, 78);
    send_bit(0, 100, 50);
    tail = 30'h1234_5678;
    for (int i = 29; i >= 0; i--) begin
      if (tail[i]) begin
        hold(0, 1'b0, 50);
        hold(0, 1'b1, 60); hold(0, 1'b0, 2); hold(0, 1'b1, 88);
      end else begin
        send_bit(0, 150, 50);
      end
    end
    send_stop(0);
    wait_idle(0, 100, "t5");

    // 8-bit instance: start mid-frame is ignored
    pulse_start(1);
    expect_valid(1, 64'hA5);
    send_bits(1, 64'hA, 4);
    pulse_start(1);
    chk("t6_busy_mid_frame", 64'(bus1.busy), 1);
    send_bits(1, 64'h5, 4);
    send_stop(1);
    wait_idle(1, 100, "t6");
    hold(1, 1'b1, 20);
    chk("t6_data_hold", 64'(bus1.data), 64'hA5);

    // Reset mid-frame aborts silently; next frame is received normally
    pulse_start(1);
    send_bits(1, 64'h5, 3);
    hold(1, 1'b0, 30);
    reset1 = 1'b1;
    #1;
    chk("t7_busy_in_reset", 64'(bus1.busy), 0);
    chk("t7_valid_in_reset", 64'(bus1.data_valid), 0);
    chk("t7_error_in_reset", 64'(bus1.error), 0);
    hold(1, 1'b1, 3);
    reset1 = 1'b0;
    hold(1, 1'b1, 10);
    chk("t7_busy_after_reset", 64'(bus1.busy), 0);
    pulse_start(1);
    expect_valid(1, 64'h3C);
    send_bits(1, 64'h3C, 8);
    send_stop(1);
    wait_idle(1, 100, "t7");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_n64_frame_receiver
`default_nettype wire
